// File: rtl/pack_rd_if.sv
// Framed packet stream from pack_rd toward the uplink/transmit logic.
// The master drives data/valid/sop/eop; the slave returns pk_rdy.
interface pack_rd_if;
  logic [31:0] pk_data;
  logic        pk_vld;
  logic        pk_sop;
  logic        pk_eop;
  logic        pk_rdy;

  modport master (output pk_data, pk_vld, pk_sop, pk_eop, input pk_rdy);
  modport slave  (input pk_data, pk_vld, pk_sop, pk_eop, output pk_rdy);
endinterface

// File: rtl/pack_rd.sv
// Reads the completed half-bank of the pack sample buffer and serialises it
// into header / per-sample UTC,NS,X,Y,Z / checksum frames.
module pack_rd #(
  parameter int unsigned RD_LAT    = 2,
  parameter logic [15:0] SYNC_WORD = 16'hA5A5
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        syn_vld,
  input  logic [11:0] buf_waddr,
  output logic [11:0] buf_raddr,
  input  logic [31:0] q_x,
  input  logic [31:0] q_y,
  input  logic [31:0] q_z,
  input  logic [31:0] q_utc,
  input  logic [31:0] q_ns,
  output logic        pk_busy,
  output logic        pk_ovr,
  pack_rd_if.master   pk
);

  localparam int unsigned WCNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam int unsigned IDX_W  = 11;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_RD, S_WAIT, S_SEND, S_CSUM
  } state_t;

  state_t              state_q, state_d;
  logic                bank_q, bank_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [2:0]          w_q, w_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]         hold_q [5];
  logic [31:0]         hold_d [5];
  logic [31:0]         seq_q, seq_d;
  logic [31:0]         csum_q, csum_d;
  logic [11:0]         raddr_q, raddr_d;
  logic [31:0]         data_q, data_d;
  logic                vld_q, vld_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;
  logic                xfer;

  assign xfer = vld_q & pk.pk_rdy;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    w_d     = w_q;
    wcnt_d  = wcnt_q;
    hold_d  = hold_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    raddr_d = raddr_q;
    data_d  = data_q;
    ovr_d   = syn_vld & (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (syn_vld) begin
          bank_d  = buf_waddr[11];
          cnt_d   = buf_waddr[10:0];
          csum_d  = '0;
          state_d = S_HDR0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          csum_d  = csum_q + data_q;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          csum_d = csum_q + data_q;
          seq_d  = seq_q + 32'd1;
          idx_d  = '0;
          state_d = (cnt_q == '0) ? S_CSUM : S_RD;
        end
      end
      S_RD: begin
        raddr_d = {bank_q, idx_q};
        wcnt_d  = WCNT_W'(RD_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data is valid once RD_LAT cycles have elapsed since the address change
        if (wcnt_q == '0) begin
          hold_d[0] = q_utc;
          hold_d[1] = q_ns;
          hold_d[2] = q_x;
          hold_d[3] = q_y;
          hold_d[4] = q_z;
          w_d       = '0;
          state_d   = S_SEND;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      S_SEND: begin
        if (xfer) begin
          csum_d = csum_q + data_q;
          if (w_q == 3'd4) begin
            w_d     = '0;
            idx_d   = idx_q + IDX_W'(1);
            state_d = (IDX_W'(idx_q + IDX_W'(1)) == cnt_q) ? S_CSUM : S_RD;
          end else begin
            w_d = w_q + 3'd1;
          end
        end
      end
      S_CSUM: begin
        if (xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    vld_d  = (state_d == S_HDR0) || (state_d == S_HDR1) ||
             (state_d == S_SEND) || (state_d == S_CSUM);
    sop_d  = (state_d == S_HDR0);
    eop_d  = (state_d == S_CSUM);
    busy_d = (state_d != S_IDLE);

    case (state_d)
      S_HDR0: data_d = {SYNC_WORD, 5'b0, cnt_d};
      S_HDR1: data_d = seq_q;
      S_CSUM: data_d = csum_d;
      S_SEND: begin
        case (w_d)
          3'd0:    data_d = hold_d[0];
          3'd1:    data_d = hold_d[1];
          3'd2:    data_d = hold_d[2];
          3'd3:    data_d = hold_d[3];
          default: data_d = hold_d[4];
        endcase
      end
      default: data_d = data_q;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bank_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      w_q     <= '0;
      wcnt_q  <= '0;
      hold_q  <= '{default: '0};
      seq_q   <= '0;
      csum_q  <= '0;
      raddr_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      wcnt_q  <= wcnt_d;
      hold_q  <= hold_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      raddr_q <= raddr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign buf_raddr  = raddr_q;
  assign pk_busy    = busy_q;
  assign pk_ovr     = ovr_q;
  assign pk.pk_data = data_q;
  assign pk.pk_vld  = vld_q;
  assign pk.pk_sop  = sop_q;
  assign pk.pk_eop  = eop_q;

endmodule
